// File: rtl/synapse_weight_mem_axil.sv
// Synaptic-weight store: AXI4-Lite host load/readback plus a single-cycle core read port.
// Core fetches take priority over pending host reads; AW and W are accepted independently.
module synapse_weight_mem_axil #(
    parameter int NUM_SYNAPSES = 72865,
    parameter int WEIGHT_W     = 16,
    parameter int ADDR_W       = 32,
    parameter int CORE_ADDR_W  = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [ADDR_W-1:0]      s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    input  logic                   core_rd_en,
    input  logic [CORE_ADDR_W-1:0] core_rd_addr,
    output logic                   core_rd_valid,
    output logic [WEIGHT_W-1:0]    core_rd_data,
    output logic                   core_rd_err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (NUM_SYNAPSES > 1) ? $clog2(NUM_SYNAPSES) : 1;
    localparam logic [IDX_W:0]       IDX_LIMIT  = (IDX_W + 1)'(NUM_SYNAPSES);
    localparam logic [CORE_ADDR_W:0] CORE_LIMIT = (CORE_ADDR_W + 1)'(NUM_SYNAPSES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_PEND, RD_RESP} rd_state_t;

    logic [WEIGHT_W-1:0] mem [NUM_SYNAPSES];

    logic                ready_en_q;
    wr_state_t           wr_state_q, wr_state_d;
    logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
    logic [WEIGHT_W-1:0] wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;

    rd_state_t           rd_state_q, rd_state_d;
    logic [IDX_W-1:0]    ar_idx_q, ar_idx_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rvalid_q, rvalid_d;

    logic                core_valid_q, core_valid_d;
    logic [WEIGHT_W-1:0] core_data_q, core_data_d;
    logic                core_err_q, core_err_d;

    logic                aw_hs, w_hs, ar_hs;
    logic                commit, commit_in_range, mem_we;
    logic [IDX_W-1:0]    commit_idx;
    logic [WEIGHT_W-1:0] commit_data, wr_mask, wr_word;
    logic [3:0]          commit_strb;
    logic [31:0]         strb_bits;
    logic                ar_in_range, core_in_range;

    // Readies are gated by a flop so they stay low through reset and rise on the first edge after it.
    assign s_axi_awready = ready_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_DATA);
    assign s_axi_wready  = ready_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_ADDR);
    assign s_axi_arready = ready_en_q && (rd_state_q == RD_IDLE);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_idx_d    = aw_idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        commit      = 1'b0;
        commit_idx  = aw_idx_q;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    commit_idx  = s_axi_awaddr[ADDR_W-1:2];
                    commit_data = s_axi_wdata[WEIGHT_W-1:0];
                    commit_strb = s_axi_wstrb;
                end else if (aw_hs) begin
                    aw_idx_d   = s_axi_awaddr[ADDR_W-1:2];
                    wr_state_d = WR_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d    = s_axi_wdata[WEIGHT_W-1:0];
                    wstrb_d    = s_axi_wstrb;
                    wr_state_d = WR_HAVE_DATA;
                end
            end
            WR_HAVE_ADDR: begin
                if (w_hs) begin
                    commit      = 1'b1;
                    commit_data = s_axi_wdata[WEIGHT_W-1:0];
                    commit_strb = s_axi_wstrb;
                end
            end
            WR_HAVE_DATA: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    commit_idx = s_axi_awaddr[ADDR_W-1:2];
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        commit_in_range = ({1'b0, commit_idx} < IDX_LIMIT);
        if (commit) begin
            bvalid_d   = 1'b1;
            bresp_d    = commit_in_range ? RESP_OKAY : RESP_SLVERR;
            wr_state_d = WR_RESP;
        end
    end

    // Byte strobes expand to a bit mask; lanes above WEIGHT_W fall off the slice.
    assign strb_bits = {{8{commit_strb[3]}}, {8{commit_strb[2]}}, {8{commit_strb[1]}}, {8{commit_strb[0]}}};
    assign wr_mask   = strb_bits[WEIGHT_W-1:0];
    assign wr_word   = (mem[commit_idx[MEM_AW-1:0]] & ~wr_mask) | (commit_data & wr_mask);
    assign mem_we    = commit && commit_in_range && !rst;

    always_comb begin
        rd_state_d  = rd_state_q;
        ar_idx_d    = ar_idx_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rvalid_d    = rvalid_q;
        ar_in_range = ({1'b0, ar_idx_q} < IDX_LIMIT);
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    ar_idx_d   = s_axi_araddr[ADDR_W-1:2];
                    rd_state_d = RD_PEND;
                end
            end
            RD_PEND: begin
                if (!core_rd_en) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    if (ar_in_range) begin
                        rdata_d[WEIGHT_W-1:0] = mem[ar_idx_q[MEM_AW-1:0]];
                        rresp_d               = RESP_OKAY;
                    end
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        core_in_range = ({1'b0, core_rd_addr} < CORE_LIMIT);
        core_valid_d  = core_rd_en;
        core_err_d    = core_rd_en && !core_in_range;
        core_data_d   = '0;
        if (core_rd_en && core_in_range) begin
            core_data_d = mem[core_rd_addr[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q   <= 1'b0;
            wr_state_q   <= WR_IDLE;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
            rd_state_q   <= RD_IDLE;
            ar_idx_q     <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            rvalid_q     <= 1'b0;
            core_valid_q <= 1'b0;
            core_data_q  <= '0;
            core_err_q   <= 1'b0;
        end else begin
            ready_en_q   <= 1'b1;
            wr_state_q   <= wr_state_d;
            aw_idx_q     <= aw_idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rd_state_q   <= rd_state_d;
            ar_idx_q     <= ar_idx_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            rvalid_q     <= rvalid_d;
            core_valid_q <= core_valid_d;
            core_data_q  <= core_data_d;
            core_err_q   <= core_err_d;
        end
    end

    // Weight array is never reset; reads elsewhere sample it before this edge's update.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[commit_idx[MEM_AW-1:0]] <= wr_word;
        end
    end

    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign core_rd_valid = core_valid_q;
    assign core_rd_data  = core_data_q;
    assign core_rd_err   = core_err_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, strb_bits};

endmodule

// File: tb/tb_synapse_weight_mem_axil.sv
// Bench for synapse_weight_mem_axil: table-driven AXI write/readback with response scoreboards,
// plus hand-written sequences for ordering, core priority, read-during-write and reset.
module tb_synapse_weight_mem_axil;

    localparam int NUM = 72865;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        core_en = 1'b0;
    logic [16:0] core_addr = '0;
    logic        core_valid;
    logic [15:0] core_data;
    logic        core_err;

    synapse_weight_mem_axil #(
        .NUM_SYNAPSES(NUM),
        .WEIGHT_W(16),
        .ADDR_W(32),
        .CORE_ADDR_W(17)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .core_rd_en(core_en), .core_rd_addr(core_addr),
        .core_rd_valid(core_valid), .core_rd_data(core_data), .core_rd_err(core_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit ok = 0;
        awaddr = a;
        awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (awready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (wready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        if (!ok) timeout("w_handshake");
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 0;
        araddr = a;
        arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (arready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (!ok) timeout("ar_handshake");
    endtask

    task automatic wait_b();
        bit ok = 0;
        logic [1:0] e;
        bready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bvalid) begin
                ok = 1;
                if (b_q.size() == 0) begin
                    chk("b_unexpected", 32'(bvalid), 32'd0);
                end else begin
                    e = b_q.pop_front();
                    chk("bresp", 32'(bresp), 32'(e));
                end
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("bvalid");
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    // lat counts clock edges from the AR handshake edge to the edge that raised rvalid.
    task automatic wait_r(output int lat);
        bit ok = 0;
        logic [33:0] e;
        rready = 1'b1;
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            if (rvalid) begin
                ok = 1;
                if (r_q.size() == 0) begin
                    chk("r_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    e = r_q.pop_front();
                    chk("rdata", rdata, e[33:2]);
                    chk("rresp", 32'(rresp), 32'(e[1:0]));
                end
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!ok) timeout("rvalid");
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] eb);
        b_q.push_back(eb);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input bit chk_lat);
        int lat;
        r_q.push_back({ed, er});
        send_ar(a);
        wait_r(lat);
        if (chk_lat) chk("read_latency", 32'(lat), 32'd2);
    endtask

    task automatic core_read(input logic [16:0] a, input logic [15:0] ed, input logic ee);
        core_en = 1'b1;
        core_addr = a;
        @(negedge clk);
        chk("core_valid", 32'(core_valid), 32'd1);
        chk("core_data", 32'(core_data), 32'(ed));
        chk("core_err", 32'(core_err), 32'(ee));
        core_en = 1'b0;
        @(negedge clk);
        chk("core_valid_idle", 32'(core_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] e;
        tbl.push_back('{32'h10, 32'h0000ABCD, 4'hF, 2'b00, 32'h0000ABCD, 2'b00});
        tbl.push_back('{32'h20, 32'h00001234, 4'hF, 2'b00, 32'h00001234, 2'b00});
        tbl.push_back('{32'h24, 32'hFFFF5A5A, 4'hF, 2'b00, 32'h00005A5A, 2'b00});
        tbl.push_back('{32'h28, 32'h0000BEEF, 4'hF, 2'b00, 32'h0000BEEF, 2'b00});
        tbl.push_back('{32'h28, 32'h00000077, 4'h1, 2'b00, 32'h0000BE77, 2'b00});
        tbl.push_back('{32'h28, 32'h00001234, 4'h0, 2'b00, 32'h0000BE77, 2'b00});
        tbl.push_back('{32'h28, 32'h00FF0000, 4'h4, 2'b00, 32'h0000BE77, 2'b00});
        tbl.push_back('{32'h28, 32'h0000AA00, 4'h2, 2'b00, 32'h0000AA77, 2'b00});
        tbl.push_back('{32'(4 * (NUM - 1)), 32'h00000042, 4'hF, 2'b00, 32'h00000042, 2'b00});
        tbl.push_back('{32'(4 * NUM), 32'h00009999, 4'hF, 2'b10, 32'h0, 2'b10});
        tbl.push_back('{32'hFFFFFFFC, 32'h00009999, 4'hF, 2'b10, 32'h0, 2'b10});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_readies", 32'({awready, wready, arready}), 32'd0);
        chk("rst_outs", 32'(|{bvalid, bresp, rvalid, rresp, rdata, core_valid, core_data, core_err}), 32'd0);
        rst = 1'b0;
        #1;
        chk("release_ready_low", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("release_ready_high", 32'({awready, wready, arready}), 32'd7);

        // Table: same-cycle AW/W write then readback
        foreach (tbl[i]) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].bresp);
            do_read(tbl[i].addr, tbl[i].rdata, tbl[i].rresp, 1'b1);
        end
        do_read(32'(4 * (NUM - 1)), 32'h42, 2'b00, 1'b1);
        core_read(17'(NUM - 1), 16'h0042, 1'b0);
        core_read(17'(NUM), 16'h0000, 1'b1);
        core_read(17'd4, 16'hABCD, 1'b0);

        // W leads AW by three cycles; merge one byte into 0x1234
        b_q.push_back(2'b00);
        fork
            send_w(32'h00005500, 4'h2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("no_early_bvalid", 32'(bvalid), 32'd0);
                end
                send_aw(32'h20);
            end
        join
        wait_b();
        repeat (3) begin
            @(negedge clk);
            chk("single_bvalid", 32'(bvalid), 32'd0);
        end
        do_read(32'h20, 32'h5534, 2'b00, 1'b1);

        // Core holds priority over a pending host read for five cycles
        core_en = 1'b1;
        core_addr = 17'd4;
        araddr = 32'h10;
        arvalid = 1'b1;
        chk("prio_arready", 32'(arready), 32'd1);
        r_q.push_back({32'h0000ABCD, 2'b00});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            arvalid = 1'b0;
            chk("prio_core_valid", 32'(core_valid), 32'd1);
            chk("prio_core_data", 32'(core_data), 32'hABCD);
            chk("prio_rvalid_held", 32'(rvalid), 32'd0);
            if (i == 5) core_en = 1'b0;
        end
        @(negedge clk);
        chk("prio_core_idle", 32'(core_valid), 32'd0);
        chk("prio_rvalid", 32'(rvalid), 32'd1);
        e = r_q.pop_front();
        chk("prio_rdata", rdata, e[33:2]);
        chk("prio_rresp", 32'(rresp), 32'(e[1:0]));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("prio_rvalid_drop", 32'(rvalid), 32'd0);

        // Core read on the commit edge sees the old weight
        do_write(32'h20, 32'h1111, 4'hF, 2'b00);
        core_en = 1'b1;
        core_addr = 17'd8;
        b_q.push_back(2'b00);
        fork
            send_aw(32'h20);
            send_w(32'h2222, 4'hF);
        join
        chk("rdw_old", 32'(core_data), 32'h1111);
        @(negedge clk);
        chk("rdw_new", 32'(core_data), 32'h2222);
        core_en = 1'b0;
        wait_b();

        // Reset while the write side holds an address and the read side holds a response
        araddr = 32'h10;
        send_ar(32'h10);
        for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        send_aw(32'h20);
        chk("have_addr_ready", 32'({awready, wready}), 32'b01);
        wdata = 32'h3333;
        wstrb = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_readies", 32'({awready, wready, arready}), 32'd0);
        chk("mid_rst_outs", 32'(|{bvalid, bresp, rvalid, rresp, rdata, core_valid, core_data, core_err}), 32'd0);
        @(negedge clk);
        chk("mid_rst_hold", 32'(|{awready, wready, arready, bvalid, rvalid, rdata}), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_release_low", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("mid_release_high", 32'({awready, wready, arready}), 32'd7);
        chk("mid_release_valids", 32'({bvalid, rvalid}), 32'd0);
        b_q.delete();
        r_q.delete();
        core_read(17'd8, 16'h2222, 1'b0);
        do_read(32'h20, 32'h2222, 2'b00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
